// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one single-port 32-bit memory, with address fault checks.
// Define MEM_ARB_RR_EN for round-robin arbitration of simultaneous requests; default is data-first.
module mem_arbiter #(
  parameter logic [31:0] ENTRY = 32'h8000_0000,
  parameter int          DEPTH = 2056,
  localparam int         IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic [31:0]      i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic             i_err,
  output logic [31:0]      i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [3:0]       d_be,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic             d_err,
  output logic [31:0]      d_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [IDX_W-1:0] mem_idx,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic        r_err_p1;
  logic        r_wr_p1;
  logic        w_sel_i;
  logic        w_sel_d;
  logic        w_gnt;
  logic        w_fault;
  logic        w_wr;
  logic [31:0] w_addr;

  // The upper bound is formed in 33 bits so ENTRY + 4*DEPTH cannot wrap.
  function automatic logic addr_fault(input logic [31:0] a);
    logic [32:0] lim;
    lim = {1'b0, ENTRY} + (33'(DEPTH) << 2);
    return (a < ENTRY) || ({1'b0, a} >= lim) || (a[1:0] != 2'b00);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return IDX_W'((a - ENTRY) >> 2);
  endfunction

`ifdef MEM_ARB_RR_EN
  // Set means the fetch port won the last contended grant, so data goes next.
  logic r_last_i_win;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_last_i_win <= 1'b1;
    else if (i_req && d_req)
      r_last_i_win <= w_sel_i;
  end
`endif

  // Request selection; gated by reset so nothing is granted while it is held.
  always_comb begin
    w_sel_i = 1'b0;
    w_sel_d = 1'b0;
    if (reset) begin
`ifdef MEM_ARB_RR_EN
      if (i_req && d_req) begin
        w_sel_d = r_last_i_win;
        w_sel_i = !r_last_i_win;
      end else begin
        w_sel_d = d_req;
        w_sel_i = i_req;
      end
`else
      w_sel_d = d_req;
      w_sel_i = i_req && !d_req;
`endif
    end
  end

  assign w_gnt   = w_sel_i || w_sel_d;
  assign w_addr  = w_sel_d ? d_addr : i_addr;
  assign w_fault = addr_fault(w_addr);
  assign w_wr    = w_sel_d && d_we;

  // Stage p0 -> p1: state and response attributes captured at grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_gnt) begin
      r_err_p1 <= w_fault;
      r_wr_p1  <= w_wr;
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    i_gnt       = w_sel_i;
    d_gnt       = w_sel_d;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_be      = 4'h0;
    mem_idx     = '0;
    mem_wdata   = 32'h0;
    i_rvalid    = 1'b0;
    i_err       = 1'b0;
    i_rdata     = 32'h0;
    d_rvalid    = 1'b0;
    d_err       = 1'b0;
    d_rdata     = 32'h0;

    if (w_sel_d)
      w_state_nxt = RESP_D;
    else if (w_sel_i)
      w_state_nxt = RESP_I;

    if (w_gnt && !w_fault) begin
      mem_en  = 1'b1;
      mem_idx = addr_idx(w_addr);
      if (w_wr) begin
        mem_we    = 1'b1;
        mem_be    = d_be;
        mem_wdata = d_wdata;
      end else begin
        mem_be    = 4'hF;
      end
    end

    // Responses: reads return the memory word, writes and faults return zero.
    case (r_state)
      RESP_I: begin
        i_rvalid = 1'b1;
        i_err    = r_err_p1;
        if (!r_err_p1)
          i_rdata = mem_rdata;
      end
      RESP_D: begin
        d_rvalid = 1'b1;
        d_err    = r_err_p1;
        if (!r_err_p1 && !r_wr_p1)
          d_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default parameters; both arbitration builds).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [11:0] mem_idx;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_idx(mem_idx),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // End the current cycle, drop requests and settle past the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
  endtask

  initial begin
    logic exp_d;
    reset     = 1'b0;
    i_req     = 1'b1;
    d_req     = 1'b1;
    d_we      = 1'b1;
    d_be      = 4'hF;
    i_addr    = 32'h8000_0010;
    d_addr    = 32'h8000_0020;
    d_wdata   = 32'h1234_5678;
    mem_rdata = 32'h0000_0013;

    // Reset held with requests pending: everything quiet.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_i_gnt", {31'h0, i_gnt}, 32'h0);
    chk("rst_d_gnt", {31'h0, d_gnt}, 32'h0);
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h0);
    chk("rst_rdata", i_rdata | d_rdata, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h0);
    chk("idle_rdata", i_rdata | d_rdata, 32'h0);

    // Fetch read.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h8000_0010;
    #1;
    chk("fetch_i_gnt", {31'h0, i_gnt}, 32'h1);
    chk("fetch_d_gnt", {31'h0, d_gnt}, 32'h0);
    chk("fetch_mem_en", {31'h0, mem_en}, 32'h1);
    chk("fetch_mem_we", {31'h0, mem_we}, 32'h0);
    chk("fetch_mem_be", {28'h0, mem_be}, 32'hF);
    chk("fetch_mem_idx", {20'h0, mem_idx}, 32'd4);
    next_cycle();
    chk("fetch_i_rvalid", {31'h0, i_rvalid}, 32'h1);
    chk("fetch_i_err", {31'h0, i_err}, 32'h0);
    chk("fetch_i_rdata", i_rdata, 32'h0000_0013);
    chk("fetch_d_rvalid", {31'h0, d_rvalid}, 32'h0);
    chk("fetch_d_rdata", d_rdata, 32'h0);

    // Data write; fetch read response and write both avoid stale data.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011;
    d_addr = 32'h8000_0020; d_wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_d_gnt", {31'h0, d_gnt}, 32'h1);
    chk("wr_mem_en", {31'h0, mem_en}, 32'h1);
    chk("wr_mem_we", {31'h0, mem_we}, 32'h1);
    chk("wr_mem_idx", {20'h0, mem_idx}, 32'd8);
    chk("wr_mem_be", {28'h0, mem_be}, 32'h3);
    chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    next_cycle();
    chk("wr_d_rvalid", {31'h0, d_rvalid}, 32'h1);
    chk("wr_d_err", {31'h0, d_err}, 32'h0);
    chk("wr_d_rdata", d_rdata, 32'h0);
    chk("wr_i_rvalid", {31'h0, i_rvalid}, 32'h0);

    // Data read at the last valid word.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_201C;
    mem_rdata = 32'hCAFE_F00D;
    #1;
    chk("last_mem_en", {31'h0, mem_en}, 32'h1);
    chk("last_mem_idx", {20'h0, mem_idx}, 32'd2055);
    chk("last_mem_be", {28'h0, mem_be}, 32'hF);
    next_cycle();
    chk("last_d_rdata", d_rdata, 32'hCAFE_F00D);
    chk("last_d_err", {31'h0, d_err}, 32'h0);

    // Data read one past the end: faulty.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_2020;
    #1;
    chk("oob_d_gnt", {31'h0, d_gnt}, 32'h1);
    chk("oob_mem_en", {31'h0, mem_en}, 32'h0);
    next_cycle();
    chk("oob_d_rvalid", {31'h0, d_rvalid}, 32'h1);
    chk("oob_d_err", {31'h0, d_err}, 32'h1);
    chk("oob_d_rdata", d_rdata, 32'h0);

    // Misaligned fetch: faulty.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h8000_0002;
    #1;
    chk("mis_i_gnt", {31'h0, i_gnt}, 32'h1);
    chk("mis_mem_en", {31'h0, mem_en}, 32'h0);
    next_cycle();
    chk("mis_i_rvalid", {31'h0, i_rvalid}, 32'h1);
    chk("mis_i_err", {31'h0, i_err}, 32'h1);
    chk("mis_i_rdata", i_rdata, 32'h0);

    // Fetch below ENTRY: faulty.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h7FFF_FFFC;
    #1;
    chk("low_mem_en", {31'h0, mem_en}, 32'h0);
    next_cycle();
    chk("low_i_err", {31'h0, i_err}, 32'h1);

    // Contention for four cycles.
    i_addr = 32'h8000_0010; d_addr = 32'h8000_0020; d_we = 1'b0;
    @(negedge clk);
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      #1;
      chk($sformatf("cont%0d_d_gnt", k), {31'h0, d_gnt}, {31'h0, exp_d});
      chk($sformatf("cont%0d_i_gnt", k), {31'h0, i_gnt}, {31'h0, !exp_d});
      @(posedge clk);
      #1;
      chk($sformatf("cont%0d_d_rvalid", k), {31'h0, d_rvalid}, {31'h0, exp_d});
      chk($sformatf("cont%0d_i_rvalid", k), {31'h0, i_rvalid}, {31'h0, !exp_d});
      @(negedge clk);
    end
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk);
    #1;
    chk("cont_end_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h0);

    // Reset while a fetch response is pending.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h8000_0010;
    @(posedge clk);
    #1;
    i_req = 1'b0;
    reset = 1'b0;
    #1;
    chk("rstmid_i_rvalid", {31'h0, i_rvalid}, 32'h0);
    chk("rstmid_i_rdata", i_rdata, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst%0d_rvalid", k), {30'h0, i_rvalid, d_rvalid}, 32'h0);
    end

    // Priority after reset is data-first in both builds.
    @(negedge clk);
    i_req = 1'b1; d_req = 1'b1;
    #1;
    chk("rr_rst_d_gnt", {31'h0, d_gnt}, 32'h1);
    chk("rr_rst_i_gnt", {31'h0, i_gnt}, 32'h0);
    next_cycle();
    chk("rr_rst_d_rvalid", {31'h0, d_rvalid}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
